// File: rtl/avalon_mem_responder_if.sv
// Avalon-style memory bus between a CPU-side initiator (master) and a memory responder (slave).
// The slave holds the request until it drops waitrequest.
interface avalon_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// Word-organised RAM responder with byte-lane writes, an address window and fixed wait states.
// Define AVALON_MEM_RANDOM_WAIT_EN to add 0..3 pseudo-random extra wait states per transaction.
module avalon_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input logic                   clk,
    input logic                   reset,
    avalon_mem_responder_if.slave bus
);
    localparam int          WORDS     = 2**DEPTH_LOG2;
    localparam logic [32:0] WIN_BYTES = 33'(WORDS) << 2;
    localparam logic [4:0]  WAIT_INIT = 5'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, wait_ld;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d;

    logic [31:0] mem [WORDS];

    logic                  req_one, wait_req, eff_wr, in_win;
    logic [31:0]           eff_addr, offset;
    logic [DEPTH_LOG2-1:0] idx;

    assign req_one = bus.read ^ bus.write;

    // IDLE->ACK with zero wait has nothing latched yet, so decode the live bus there
    assign eff_addr = (state_q == IDLE) ? bus.address : addr_q;
    assign eff_wr   = (state_q == IDLE) ? bus.write   : wr_q;
    assign offset   = eff_addr - BASE_ADDR;
    assign in_win   = {1'b0, offset} < WIN_BYTES;
    assign idx      = offset[DEPTH_LOG2+1:2];

`ifdef AVALON_MEM_RANDOM_WAIT_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign wait_ld = WAIT_INIT + {3'b000, lfsr_q[1:0]};
`else
    assign wait_ld = WAIT_INIT;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wait_req = 1'b0;
`ifdef AVALON_MEM_RANDOM_WAIT_EN
        lfsr_d   = lfsr_q;
`endif
        unique case (state_q)
            IDLE: begin
                wait_req = req_one;
                if (req_one) begin
                    addr_d  = bus.address;
                    wr_d    = bus.write;
                    be_d    = bus.byteenable;
                    wdata_d = bus.writedata;
                    cnt_d   = wait_ld;
                    state_d = (wait_ld != 5'd0) ? BUSY : ACK;
`ifdef AVALON_MEM_RANDOM_WAIT_EN
                    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                end
            end
            BUSY: begin
                // Deasserting the request here does not cancel the latched transfer
                wait_req = bus.read | bus.write;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ACK && !eff_wr) rdata_d = in_win ? mem[idx] : 32'h0;
    end

    assign bus.waitrequest = reset & wait_req;
    assign bus.readdata    = rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            addr_q  <= 32'h0;
            wr_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef AVALON_MEM_RANDOM_WAIT_EN
            lfsr_q  <= 8'hA5;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef AVALON_MEM_RANDOM_WAIT_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    // Write commits leaving ACK; a reset on that edge drops it
    always_ff @(posedge clk) begin
        if (reset && state_q == ACK && wr_q && in_win) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: a transaction-level memory model predicts
// waitrequest and readdata every cycle, plus literal spot checks.
module tb_avalon_mem_responder;
    localparam logic [31:0] BASE        = 32'hBFC00000;
    localparam int          DEPTH_LOG2  = 10;
    localparam int          WAIT_CYCLES = 1;
    localparam logic [31:0] WIN         = 32'd4 << DEPTH_LOG2;

    logic clk;
    logic reset;
    avalon_mem_responder_if bus();

    avalon_mem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          chk_en = 1'b0;
    logic        exp_wr = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    logic [31:0] mem_m [int];
    logic [7:0]  lfsr_m = 8'hA5;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("waitrequest", {31'h0, bus.waitrequest}, {31'h0, exp_wr});
            check("readdata", bus.readdata, exp_rd);
        end
    end

    function automatic int next_wait();
`ifdef AVALON_MEM_RANDOM_WAIT_EN
        int e;
        e = int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        return WAIT_CYCLES + e;
`else
        return WAIT_CYCLES;
`endif
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= WIN) return 32'h0;
        return mem_m.exists(int'(off >> 2)) ? mem_m[int'(off >> 2)] : 32'h0;
    endfunction

    task automatic mdl_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] off, v;
        off = a - BASE;
        if (off < WIN) begin
            v = mem_m.exists(int'(off >> 2)) ? mem_m[int'(off >> 2)] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
            mem_m[int'(off >> 2)] = v;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        exp_wr = 1'b0;
        @(posedge clk); #1;
        exp_rd = 32'h0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        lfsr_m = 8'hA5;
    endtask

    // Entered and left at posedge+1; drop=1 releases the request after the first cycle
    task automatic txn(input bit rd, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input bit drop, output int hi);
        int w;
        w = next_wait();
        hi = 0;
        bus.address = a;
        bus.read = rd;
        bus.write = !rd;
        bus.byteenable = be;
        bus.writedata = wd;
        for (int k = 0; k <= w; k++) begin
            exp_wr = (k == 0) || !drop;
            @(negedge clk);
            if (bus.waitrequest) hi++;
            @(posedge clk); #1;
            if (k == 0 && drop) begin
                bus.read = 1'b0;
                bus.write = 1'b0;
                bus.address = 32'h0000_0040;
                bus.writedata = 32'h5555_5555;
            end
        end
        exp_wr = 1'b0;
        if (rd) exp_rd = mdl_rd(a);
        @(posedge clk); #1;
        if (!rd) mdl_wr(a, be, wd);
        bus.read = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
        int hi;
        reset = 1'b0;
        bus.address = 32'h0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.byteenable = 4'h0;
        bus.writedata = 32'h0;
        do_reset();

        // Give the words under test known contents; reset must not clear them
        for (int i = 0; i < 3; i++) txn(1'b0, BASE + 32'(4*i), 4'hF, 32'h0, 1'b0, hi);
        do_reset();

        txn(1'b1, BASE, 4'hF, 32'h0, 1'b0, hi);
`ifndef AVALON_MEM_RANDOM_WAIT_EN
        check("lit_read_wait_cycles", 32'(hi), 32'd2);
`endif
        check("lit_read_word0", bus.readdata, 32'h0);

        txn(1'b0, 32'hBFC00004, 4'hF, 32'hDEADBEEF, 1'b0, hi);
        txn(1'b1, 32'hBFC00004, 4'hF, 32'h0, 1'b0, hi);
        check("lit_raw_full", bus.readdata, 32'hDEADBEEF);

        txn(1'b0, 32'hBFC00004, 4'b0101, 32'h11223344, 1'b0, hi);
        txn(1'b1, 32'hBFC00004, 4'hF, 32'h0, 1'b0, hi);
        check("lit_byte_lanes", bus.readdata, 32'hDE22BE44);

        txn(1'b0, 32'hBFC00004, 4'b0000, 32'hFFFFFFFF, 1'b0, hi);
        txn(1'b1, 32'hBFC00004, 4'hF, 32'h0, 1'b0, hi);
        check("lit_be_none", bus.readdata, 32'hDE22BE44);

        txn(1'b1, 32'h00000000, 4'hF, 32'h0, 1'b0, hi);
        check("lit_below_window", bus.readdata, 32'h0);
        txn(1'b1, 32'hBFC00004, 4'hF, 32'h0, 1'b0, hi);
        txn(1'b1, 32'hBFC01000, 4'hF, 32'h0, 1'b0, hi);
        check("lit_above_window", bus.readdata, 32'h0);
        txn(1'b0, 32'hBFC01000, 4'hF, 32'h12345678, 1'b0, hi);
        txn(1'b1, BASE, 4'hF, 32'h0, 1'b0, hi);
        check("lit_oow_write_dropped", bus.readdata, 32'h0);

        // Simultaneous read and write is ignored outright
        bus.address = 32'hBFC00004;
        bus.read = 1'b1;
        bus.write = 1'b1;
        bus.byteenable = 4'hF;
        bus.writedata = 32'h0BADF00D;
        exp_wr = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.read = 1'b0;
        bus.write = 1'b0;
        txn(1'b1, 32'hBFC00004, 4'hF, 32'h0, 1'b0, hi);
        check("lit_rw_both_ignored", bus.readdata, 32'hDE22BE44);

        txn(1'b0, 32'hBFC00008, 4'hF, 32'hA5A5A5A5, 1'b1, hi);
        txn(1'b1, 32'hBFC00008, 4'hF, 32'h0, 1'b0, hi);
        check("lit_dropped_req_commits", bus.readdata, 32'hA5A5A5A5);

        // Reset while BUSY aborts the pending write
        bus.address = 32'hBFC00004;
        bus.write = 1'b1;
        bus.byteenable = 4'hF;
        bus.writedata = 32'hCAFEF00D;
        exp_wr = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_wr = 1'b0;
        @(posedge clk); #1;
        exp_rd = 32'h0;
        bus.write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        lfsr_m = 8'hA5;
        txn(1'b1, 32'hBFC00004, 4'hF, 32'h0, 1'b0, hi);
        check("lit_reset_aborts_write", bus.readdata, 32'hDE22BE44);

        for (int i = 0; i < 8; i++) txn(1'b1, BASE + 32'(4*(i % 3)), 4'hF, 32'h0, 1'b0, hi);

        exp_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
